// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// ------------
// Single-outstanding memory request controller that sits between a core's
// load/store unit and a byte-lane-addressed block RAM. A request is taken
// in IDLE, steered through ACCESS (one BRAM enable cycle), an optional WAIT
// that covers the remaining BRAM read latency, and a one-cycle RESP pulse.
// Misaligned/illegal requests and MEM_DISABLE skip the BRAM entirely and go
// straight to RESP.
//
// Lane order is big-endian within the BRAM word: byte offset k lives in
// bramDin[31-8k:24-8k] and is enabled by bramWe[3-k]. Store data arrives
// LSB-aligned, so it is byte-reversed into place.
//
// Ports
//   clk        in   1           sole clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   reqValid   in   1           request present
//   reqReady   out  1           high only in IDLE; accept = reqValid && reqReady
//   memOp      in   2           operation code (MEM_*)
//   memSize    in   2           access size (BYTE/HALFWORD/WORD)
//   aluIn      in   32          byte address
//   storeData  in   32          store data, LSB-aligned
//   bramEn     out  1           BRAM enable, ACCESS cycle only
//   bramWe     out  4           byte write enables, ACCESS cycle only
//   bramAddr   out  ADDR_WIDTH  word address captured at accept
//   bramDin    out  32          lane-placed store data captured at accept
//   rspValid   out  1           one-cycle completion pulse
//   rspAddrLo  out  2           captured aluIn[1:0]
//   rspSize    out  2           captured memSize
//   rspOp      out  2           captured memOp
//   misalign   out  1           completed request was misaligned/illegal

module mem_req_ctrl #(
  parameter int         ADDR_WIDTH    = 12,
  parameter int         RD_LATENCY    = 1,
  parameter logic [1:0] MEM_DISABLE   = 2'b00,
  parameter logic [1:0] MEM_READ_SEXT = 2'b01,
  parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
  parameter logic [1:0] MEM_WRITE     = 2'b11,
  parameter logic [1:0] BYTE          = 2'b00,
  parameter logic [1:0] HALFWORD      = 2'b01,
  parameter logic [1:0] WORD          = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [1:0]            memOp,
  input  logic [1:0]            memSize,
  input  logic [31:0]           aluIn,
  input  logic [31:0]           storeData,
  output logic                  bramEn,
  output logic [3:0]            bramWe,
  output logic [ADDR_WIDTH-1:0] bramAddr,
  output logic [31:0]           bramDin,
  output logic                  rspValid,
  output logic [1:0]            rspAddrLo,
  output logic [1:0]            rspSize,
  output logic [1:0]            rspOp,
  output logic                  misalign
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Cycles spent in WAIT after the ACCESS cycle; at most 2 for the legal
  // latency range, so a 2-bit down-counter is enough.
  localparam logic [1:0] WAIT_CYCLES = 2'(RD_LATENCY - 1);

  logic [1:0]  state;
  logic [1:0]  wait_cnt;
  logic [3:0]  we_hold;
  logic        accept;
  logic        is_misaligned;
  logic        bypass;
  logic [35:0] placed;

  // Alignment rule: halfwords need an even address, words a 4-byte aligned
  // address, and size code 2'b11 is never legal.
  function automatic logic check_misaligned(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11)
      bad = 1'b1;
    else if (size == HALFWORD)
      bad = lo[0];
    else if (size == WORD)
      bad = (lo != 2'b00);
    return bad;
  endfunction

  // Returns {write_enables, lane_data}. Bytes are placed big-endian: the
  // lowest store byte lands in the lane of the addressed byte offset.
  function automatic logic [35:0] place_store(input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] sd);
    logic [35:0] res;
    res = 36'h0;
    if (size == BYTE)
      res = {4'b1000 >> off, {4{sd[7:0]}}};
    else if (size == HALFWORD)
      res = off[1] ? {4'b0011, 16'h0000, sd[7:0], sd[15:8]}
                   : {4'b1100, sd[7:0], sd[15:8], 16'h0000};
    else if (size == WORD)
      res = {4'b1111, sd[7:0], sd[15:8], sd[23:16], sd[31:24]};
    return res;
  endfunction

  assign accept        = reqValid && reqReady;
  assign is_misaligned = check_misaligned(memSize, aluIn[1:0]);
  assign bypass        = is_misaligned || (memOp == MEM_DISABLE);
  assign placed        = place_store(memSize, aluIn[1:0], storeData);

  // Handshake and BRAM strobes are decoded from state so that an
  // asynchronous reset drops them in the same cycle it is asserted.
  assign reqReady = (state == S_IDLE);
  assign bramEn   = (state == S_ACCESS);
  assign bramWe   = (state == S_ACCESS) ? we_hold : 4'b0000;
  assign rspValid = (state == S_RESP);

  // Address bits above the BRAM word address are not decoded here.
  generate
    if (ADDR_WIDTH < 30) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^aluIn[31:ADDR_WIDTH+2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 2'd0;
      we_hold   <= 4'b0000;
      bramAddr  <= '0;
      bramDin   <= 32'h0;
      rspAddrLo <= 2'b00;
      rspSize   <= 2'b00;
      rspOp     <= 2'b00;
      misalign  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rspAddrLo <= aluIn[1:0];
            rspSize   <= memSize;
            rspOp     <= memOp;
            bramAddr  <= aluIn[ADDR_WIDTH+1:2];
            bramDin   <= placed[31:0];
            // Loads never write; MEM_DISABLE is reported as a clean completion.
            we_hold   <= (memOp == MEM_WRITE) ? placed[35:32] : 4'b0000;
            misalign  <= is_misaligned && (memOp != MEM_DISABLE);
            state     <= bypass ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if ((rspOp == MEM_WRITE) || (WAIT_CYCLES == 2'd0)) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= WAIT_CYCLES;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt <= 2'd1) begin
            wait_cnt <= 2'd0;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl (RD_LATENCY = 2). Directed steps followed by
// randomized requests; expected timing and lane placement come from a
// byte-level model of the request rules.

module tb_mem_req_ctrl;

  localparam int         AW = 12;
  localparam int         RL = 2;
  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;
  localparam logic [1:0] BYTE          = 2'b00;
  localparam logic [1:0] HALFWORD      = 2'b01;
  localparam logic [1:0] WORD          = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [1:0]    memOp = 2'b00;
  logic [1:0]    memSize = 2'b00;
  logic [31:0]   aluIn = 32'h0;
  logic [31:0]   storeData = 32'h0;
  logic          bramEn;
  logic [3:0]    bramWe;
  logic [AW-1:0] bramAddr;
  logic [31:0]   bramDin;
  logic          rspValid;
  logic [1:0]    rspAddrLo;
  logic [1:0]    rspSize;
  logic [1:0]    rspOp;
  logic          misalign;

  int errors = 0;
  int checks = 0;

  mem_req_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
    .memOp(memOp), .memSize(memSize), .aluIn(aluIn), .storeData(storeData),
    .bramEn(bramEn), .bramWe(bramWe), .bramAddr(bramAddr), .bramDin(bramDin),
    .rspValid(rspValid), .rspAddrLo(rspAddrLo), .rspSize(rspSize),
    .rspOp(rspOp), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Byte-level model: each stored byte j goes to offset off+j, and offset k
  // occupies bits [31-8k -: 8] with enable bit 3-k. Byte stores replicate.
  function automatic logic [35:0] exp_lane(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] sd);
    logic [31:0] d;
    logic [3:0]  w;
    int          n;
    int          k;
    d = 32'h0;
    w = 4'h0;
    if (sz == BYTE) begin
      for (int i = 0; i < 4; i++) d[31-8*i -: 8] = sd[7:0];
      w[3-int'(off)] = 1'b1;
    end else begin
      n = (sz == HALFWORD) ? 2 : 4;
      for (int j = 0; j < n; j++) begin
        k = int'(off) + j;
        d[31-8*k -: 8] = sd[8*j +: 8];
        w[3-k] = 1'b1;
      end
    end
    return {w, d};
  endfunction

  // Issues one request from the IDLE sampling point (#1 after a rising edge)
  // and checks every cycle through the response plus the following IDLE.
  // With hold set, reqValid stays high with unrelated values while busy.
  task automatic do_req(input logic [1:0] op, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input bit hold);
    bit          mis;
    bit          bypass;
    int          lat;
    logic [35:0] lw;
    mis    = (sz == 2'b11) || (sz == HALFWORD && addr[0]) ||
             (sz == WORD && addr[1:0] != 2'b00);
    bypass = mis || (op == MEM_DISABLE);
    lat    = bypass ? 1 : ((op == MEM_WRITE) ? 2 : 1 + RL);
    lw     = exp_lane(sz, addr[1:0], sd);

    chk("ready_idle", reqReady, 1);
    reqValid  = 1'b1;
    memOp     = op;
    memSize   = sz;
    aluIn     = addr;
    storeData = sd;
    @(posedge clk); #1;
    if (hold) begin
      memOp     = 2'($urandom);
      memSize   = 2'($urandom);
      aluIn     = $urandom;
      storeData = $urandom;
    end else begin
      reqValid = 1'b0;
    end
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (!bypass && c == 1) begin
        chk("bram_en", bramEn, 1);
        chk("bram_addr", bramAddr, (addr >> 2) & ((32'd1 << AW) - 1));
        if (op == MEM_WRITE) begin
          chk("bram_we", bramWe, lw[35:32]);
          chk("bram_din", bramDin, lw[31:0]);
        end else begin
          chk("bram_we_load", bramWe, 0);
        end
      end else begin
        chk("bram_quiet", {bramEn, bramWe}, 0);
      end
      chk("rsp_valid", rspValid, (c == lat));
      chk("ready_busy", reqReady, 0);
      if (c == lat) begin
        chk("rsp_addr_lo", rspAddrLo, addr[1:0]);
        chk("rsp_size", rspSize, sz);
        chk("rsp_op", rspOp, op);
        chk("misalign", misalign, mis && (op != MEM_DISABLE));
      end
    end
    @(posedge clk); #1;
    chk("rsp_drop", rspValid, 0);
    chk("bram_quiet_idle", {bramEn, bramWe}, 0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    bit          r_hold;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", reqReady, 1);
    chk("rst_bram", {bramEn, bramWe}, 0);
    chk("rst_addr", bramAddr, 0);
    chk("rst_din", bramDin, 0);
    chk("rst_rsp", {rspValid, rspAddrLo, rspSize, rspOp, misalign}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed requests
    do_req(MEM_WRITE, WORD, 32'h0000_0010, 32'h1122_3344, 1'b0);
    do_req(MEM_WRITE, BYTE, 32'h0000_0007, 32'h0000_00AB, 1'b0);
    do_req(MEM_READ_SEXT, HALFWORD, 32'h0000_0006, 32'h0, 1'b0);
    do_req(MEM_READ_ZEXT, WORD, 32'h0000_0002, 32'h0, 1'b0);
    do_req(MEM_DISABLE, WORD, 32'h0000_0002, 32'h0, 1'b0);
    do_req(MEM_WRITE, HALFWORD, 32'h0000_0100, 32'h0000_CAFE, 1'b0);
    do_req(MEM_WRITE, HALFWORD, 32'h0000_0102, 32'h0000_BEEF, 1'b0);
    do_req(MEM_WRITE, BYTE, 32'h0000_0040, 32'h0000_005A, 1'b0);
    do_req(MEM_WRITE, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    do_req(MEM_READ_ZEXT, WORD, 32'h0000_3FFC, 32'h0, 1'b0);
    do_req(MEM_WRITE, HALFWORD, 32'h0000_0001, 32'h1234, 1'b0);

    // Back-to-back with reqValid held high through busy cycles (incl. WAIT)
    do_req(MEM_READ_SEXT, HALFWORD, 32'h0000_0006, 32'h0, 1'b1);
    do_req(MEM_WRITE, WORD, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1);
    do_req(MEM_WRITE, BYTE, 32'h0000_0021, 32'h0000_0077, 1'b0);

    // Reset during ACCESS of a WORD store
    reqValid  = 1'b1;
    memOp     = MEM_WRITE;
    memSize   = WORD;
    aluIn     = 32'h0000_0030;
    storeData = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk("mid_rst_en_before", bramEn, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", bramEn, 0);
    chk("mid_rst_we", bramWe, 0);
    chk("mid_rst_rsp", rspValid, 0);
    @(posedge clk); #1;
    chk("mid_rst_rsp_hold", rspValid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rsp_after", rspValid, 0);
    chk("mid_rst_ready", reqReady, 1);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (r_sz == HALFWORD) r_addr[0] = 1'b0;
        if (r_sz == WORD) r_addr[1:0] = 2'b00;
      end
      r_hold = (n != 59) && ($urandom_range(0, 1) == 1);
      do_req(r_op, r_sz, r_addr, $urandom, r_hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
